// File: rtl/clefia_con_gen.sv
// clefia_con_gen: on-the-fly generator for the CLEFIA key-schedule constants CON(k)_i.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   start, key_len        begin a sequence (00=128, 01=192, 10=256, 11=illegal -> err pulse)
//   abort                 synchronous return to IDLE, overrides everything else
//   busy, err, done       status: not idle, illegal key length, last beat accepted
//   out_valid, out_ready  beat handshake
//   out_con               WPB constants per beat, lowest index in the most significant word
//   out_idx, out_last     index of the MSW constant, beat holds CON_{N-1}
module clefia_con_gen #(
    parameter int WPB = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        key_len,
    input  logic              abort,
    output logic              busy,
    output logic              err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*WPB-1:0] out_con,
    output logic [6:0]        out_idx,
    output logic              out_last,
    output logic              done
);
    localparam int BW = 32 * WPB;
    localparam logic [15:0] P = 16'hb7e1;
    localparam logic [15:0] Q = 16'h243f;

    generate
        if (WPB != 2 && WPB != 4) begin : g_bad_wpb
            $error("clefia_con_gen: WPB must be 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, GEN, HOLD} state_t;

    state_t       state, state_nx;
    logic [15:0]  t, t_nx, iv;
    logic [6:0]   n, n_sel, idx;
    logic         cnt, gen_end, accept, hs, last_hit;
    logic [31:0]  con_e, con_o;
    logic [BW-1:0] beat;

    assign accept   = state == IDLE && start && key_len != 2'b11;
    assign gen_end  = cnt == 1'(WPB / 2 - 1);
    assign hs       = out_valid && out_ready;
    assign last_hit = idx + 7'(WPB) == n;
    assign iv       = key_len == 2'd0 ? 16'h428a : key_len == 2'd1 ? 16'h7137 : 16'hb5c0;
    assign n_sel    = key_len == 2'd0 ? 7'd60 : key_len == 2'd1 ? 7'd84 : 7'd92;
    assign con_e    = {t ^ P, ~t[14:0], ~t[15]};
    assign con_o    = {~t ^ Q, t[7:0], t[15:8]};
    // Multiplication by x^-1: fold the reduction polynomial back in when the low bit drops out.
    assign t_nx     = t[0] ? (((t ^ 16'ha831) >> 1) | 16'h8000) : (t >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort)               state_nx = IDLE;
        else if (state == IDLE)  state_nx = accept ? GEN : IDLE;
        else if (state == GEN)   state_nx = gen_end ? HOLD : GEN;
        else if (hs)             state_nx = last_hit ? IDLE : GEN;
    end

    always_comb begin
        busy      = state != IDLE;
        out_valid = state == HOLD;
        out_last  = out_valid && last_hit;
        out_con   = beat;
        out_idx   = idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t    <= '0;
            n    <= '0;
            idx  <= '0;
            cnt  <= 1'b0;
            beat <= '0;
            err  <= 1'b0;
            done <= 1'b0;
        end else begin
            err  <= !abort && state == IDLE && start && key_len == 2'b11;
            done <= !abort && hs && last_hit;
            if (!abort) begin
                if (accept) begin
                    t   <= iv;
                    n   <= n_sel;
                    idx <= '0;
                    cnt <= 1'b0;
                end else if (state == GEN) begin
                    t    <= t_nx;
                    // Older words move toward the MSW; truncation drops the stale ones.
                    beat <= BW'({beat, con_e, con_o});
                    cnt  <= !gen_end;
                end else if (hs && !last_hit) begin
                    idx <= idx + 7'(WPB);
                end
            end
        end
    end
endmodule

// File: tb/tb_clefia_con_gen.sv
// tb_clefia_con_gen: directed self-checking bench for clefia_con_gen at WPB=4 and WPB=2.
module tb_clefia_con_gen;
    logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [1:0] key_len = 2'd0;
    logic busy4, err4, v4, last4, done4, busy2, err2, v2, last2, done2;
    logic [127:0] con4;
    logic [63:0] con2;
    logic [6:0] idx4, idx2;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    clefia_con_gen #(.WPB(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .abort(abort),
        .busy(busy4), .err(err4), .out_valid(v4), .out_ready(out_ready),
        .out_con(con4), .out_idx(idx4), .out_last(last4), .done(done4)
    );

    clefia_con_gen #(.WPB(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .abort(abort),
        .busy(busy2), .err(err2), .out_valid(v2), .out_ready(out_ready),
        .out_con(con2), .out_idx(idx2), .out_last(last2), .done(done2)
    );

    function automatic logic [31:0] con_ref(input logic [15:0] iv, input int k);
        logic [15:0] t;
        t = iv;
        for (int i = 0; i < k / 2; i++) t = t[0] ? (((t ^ 16'ha831) >> 1) | 16'h8000) : (t >> 1);
        return k[0] ? {~t ^ 16'h243f, t[7:0], t[15:8]} : {t ^ 16'hb7e1, ~t[14:0], ~t[15]};
    endfunction

    function automatic logic [127:0] beat_ref(input logic [15:0] iv, input int base, input int w);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < w; j++) r = (r << 32) | {96'd0, con_ref(iv, base + j)};
        return r;
    endfunction

    task automatic idle_all();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy4, err4, v4, last4, done4, idx4} !== 12'd0 || con4 !== 128'd0) begin
            errors++;
            $display("FAIL reset4: busy=%b err=%b valid=%b last=%b done=%b idx=%0d con=%h, want all 0", busy4, err4, v4, last4, done4, idx4, con4);
        end
        checks++;
        if ({busy2, err2, v2, last2, done2, idx2} !== 12'd0 || con2 !== 64'd0) begin
            errors++;
            $display("FAIL reset2: busy=%b err=%b valid=%b last=%b done=%b idx=%0d con=%h, want all 0", busy2, err2, v2, last2, done2, idx2, con2);
        end
    endtask

    task automatic test_128();
        int beats, cyc, dn;
        logic [127:0] exp;
        beats = 0; cyc = 1; dn = 0;
        key_len = 2'd0; out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (beats < 15 && cyc < 300) begin
            if (v4) begin
                exp = beat_ref(16'h428a, beats * 4, 4);
                checks++;
                if (con4 !== exp || idx4 !== 7'(beats * 4) || last4 !== (beats == 14)) begin
                    errors++;
                    $display("FAIL beat128[%0d]: con=%h idx=%0d last=%b, want con=%h idx=%0d last=%b", beats, con4, idx4, last4, exp, beats * 4, beats == 14);
                end
                if (beats == 0) begin
                    checks++;
                    if (cyc != 3 || con4 !== 128'hf56b7aeb_994a8a42_96a4bd75_fa854521) begin
                        errors++;
                        $display("FAIL first128: latency=%0d con=%h, want latency=3 con=f56b7aeb994a8a4296a4bd75fa854521", cyc, con4);
                    end
                end
                if (beats == 6) begin
                    checks++;
                    if (idx4 !== 7'd24 || con4 !== 128'h7c6f68e2_104e8ecb_d2263471_be07c765) begin
                        errors++;
                        $display("FAIL beat6_128: idx=%0d con=%h, want idx=24 con=7c6f68e2104e8ecbd2263471be07c765", idx4, con4);
                    end
                end
                if (beats == 14) begin
                    checks++;
                    if (idx4 !== 7'd56 || last4 !== 1'b1 || con4 !== 128'h50b63150_3c9757e7_1052b098_7c73b3a7) begin
                        errors++;
                        $display("FAIL beat14_128: idx=%0d last=%b con=%h, want idx=56 last=1 con=50b631503c9757e71052b0987c73b3a7", idx4, last4, con4);
                    end
                end
                beats++;
            end
            @(negedge clk);
            cyc++;
            if (done4) dn++;
        end
        repeat (4) begin
            @(negedge clk);
            if (done4) dn++;
        end
        checks++;
        if (beats != 15 || dn != 1 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL end128: beats=%0d done_pulses=%0d busy=%b, want 15/1/0", beats, dn, busy4);
        end
    endtask

    task automatic test_192();
        int beats, cyc, dn;
        logic [63:0] exp;
        beats = 0; cyc = 1; dn = 0;
        idle_all();
        key_len = 2'd1; out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (beats < 42 && cyc < 400) begin
            if (v2) begin
                exp = 64'(beat_ref(16'h7137, beats * 2, 2));
                checks++;
                if (con2 !== exp || idx2 !== 7'(beats * 2) || last2 !== (beats == 41)) begin
                    errors++;
                    $display("FAIL beat192[%0d]: con=%h idx=%0d last=%b, want con=%h idx=%0d last=%b", beats, con2, idx2, last2, exp, beats * 2, beats == 41);
                end
                if (beats == 0) begin
                    checks++;
                    if (cyc != 2 || con2 !== 64'hc6d61d91_aaf73771) begin
                        errors++;
                        $display("FAIL first192: latency=%0d con=%h, want latency=2 con=c6d61d91aaf73771", cyc, con2);
                    end
                end
                beats++;
            end
            @(negedge clk);
            cyc++;
            if (done2) dn++;
        end
        repeat (3) begin
            @(negedge clk);
            if (done2) dn++;
        end
        checks++;
        if (beats != 42 || dn != 1 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL end192: beats=%0d done_pulses=%0d busy=%b, want 42/1/0", beats, dn, busy2);
        end
    endtask

    task automatic test_256_backpressure();
        int beats, cyc, dn;
        bit stall;
        logic [127:0] exp, held;
        logic [6:0] held_idx;
        beats = 0; cyc = 1; dn = 0; stall = 1'b0; held = '0; held_idx = '0;
        idle_all();
        key_len = 2'd2; out_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (beats < 23 && cyc < 3000) begin
            if (stall) begin
                checks++;
                if (v4 !== 1'b1 || con4 !== held || idx4 !== held_idx) begin
                    errors++;
                    $display("FAIL hold256: valid=%b con=%h idx=%0d, want valid=1 con=%h idx=%0d", v4, con4, idx4, held, held_idx);
                end
            end
            if (v4) begin
                exp = beat_ref(16'hb5c0, beats * 4, 4);
                checks++;
                if (con4 !== exp || idx4 !== 7'(beats * 4) || last4 !== (beats == 22)) begin
                    errors++;
                    $display("FAIL beat256[%0d]: con=%h idx=%0d last=%b, want con=%h idx=%0d last=%b", beats, con4, idx4, last4, exp, beats * 4, beats == 22);
                end
                if (beats == 0) begin
                    checks++;
                    if (con4[127:96] !== 32'h0221947e) begin
                        errors++;
                        $display("FAIL first256: word=%h, want 0221947e", con4[127:96]);
                    end
                end
                out_ready = 1'($urandom_range(0, 1));
                if (out_ready) begin
                    beats++;
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    held = con4;
                    held_idx = idx4;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
            if (done4) dn++;
        end
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done4) dn++;
        end
        checks++;
        if (beats != 23 || dn != 1 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL end256: beats=%0d done_pulses=%0d busy=%b, want 23/1/0", beats, dn, busy4);
        end
    endtask

    task automatic test_abort_gen();
        int dn, cyc;
        dn = 0; cyc = 1;
        idle_all();
        key_len = 2'd0; out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (v4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL abort_gen: valid=%b busy=%b, want 0/0", v4, busy4);
        end
        repeat (5) begin
            @(negedge clk);
            if (done4) dn++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!v4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (dn != 0 || cyc != 3 || idx4 !== 7'd0 || con4[127:96] !== 32'hf56b7aeb) begin
            errors++;
            $display("FAIL restart_gen: done_pulses=%0d latency=%0d idx=%0d word=%h, want 0/3/0/f56b7aeb", dn, cyc, idx4, con4[127:96]);
        end
    endtask

    task automatic test_abort_hold();
        int dn, cyc;
        dn = 0; cyc = 0;
        idle_all();
        key_len = 2'd0; out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(v4 && idx4 == 7'd24) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!(v4 && idx4 == 7'd24)) begin
            errors++;
            $display("FAIL reach_idx24: valid=%b idx=%0d, want valid=1 idx=24", v4, idx4);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (v4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold: valid=%b busy=%b, want 0/0", v4, busy4);
        end
        repeat (5) begin
            @(negedge clk);
            if (done4) dn++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!v4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (dn != 0 || idx4 !== 7'd0 || con4 !== 128'hf56b7aeb_994a8a42_96a4bd75_fa854521) begin
            errors++;
            $display("FAIL restart_hold: done_pulses=%0d idx=%0d con=%h, want 0/0/f56b7aeb994a8a4296a4bd75fa854521", dn, idx4, con4);
        end
    endtask

    task automatic test_err();
        idle_all();
        key_len = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err4 !== 1'b1 || err2 !== 1'b1 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: err4=%b err2=%b busy=%b, want 1/1/0", err4, err2, busy4);
        end
        @(negedge clk);
        checks++;
        if (err4 !== 1'b0 || busy4 !== 1'b0 || v4 !== 1'b0) begin
            errors++;
            $display("FAIL err_after: err=%b busy=%b valid=%b, want 0/0/0", err4, busy4, v4);
        end
        key_len = 2'd0;
    endtask

    task automatic test_start_busy();
        int beats, cyc, exp_idx, dn;
        logic [127:0] exp;
        beats = 0; cyc = 0; exp_idx = 12; dn = 0;
        idle_all();
        key_len = 2'd0; out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(v4 && idx4 == 7'd8) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b1;
        key_len = 2'd2;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (exp_idx <= 56 && cyc < 200) begin
            if (v4) begin
                exp = beat_ref(16'h428a, exp_idx, 4);
                checks++;
                if (con4 !== exp || idx4 !== 7'(exp_idx)) begin
                    errors++;
                    $display("FAIL busy_start: con=%h idx=%0d, want con=%h idx=%0d", con4, idx4, exp, exp_idx);
                end
                exp_idx += 4;
                beats++;
            end
            @(negedge clk);
            cyc++;
            if (done4) dn++;
        end
        checks++;
        if (beats != 12 || dn != 1) begin
            errors++;
            $display("FAIL busy_start_end: beats=%0d done_pulses=%0d, want 12/1", beats, dn);
        end
        key_len = 2'd0;
    endtask

    task automatic test_rst_mid();
        int cyc;
        cyc = 0;
        idle_all();
        key_len = 2'd0; out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!v4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy4 !== 1'b0 || v4 !== 1'b0) begin
            errors++;
            $display("FAIL after_rst: busy=%b valid=%b, want 0/0", busy4, v4);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_128();
        test_192();
        test_256_backpressure();
        test_abort_gen();
        test_abort_hold();
        test_err();
        test_start_busy();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
